// File: rtl/jpeg_pkg.sv
// Shared types and constants for the zigzag / run-length symbol stage of the JPEG pipeline.
package jpeg_pkg;

    localparam int AMP_W_DEF = 11;
    // Amplitude storage inside sym_t; size is 4 bits so AMP_W can never exceed 15.
    localparam int AMP_MAX_W = 16;

    localparam logic [5:0] ZZ_LUT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DC   = 2'd1,
        ST_SCAN = 2'd2,
        ST_EOB  = 2'd3
    } state_t;

    typedef struct packed {
        logic [3:0]           run;
        logic [3:0]           size;
        logic [AMP_MAX_W-1:0] amp;
        logic                 dc;
        logic                 last;
    } sym_t;

    localparam sym_t SYM_ZRL = '{run: 4'd15, size: 4'd0, amp: 16'd0, dc: 1'b0, last: 1'b0};
    localparam sym_t SYM_EOB = '{run: 4'd0,  size: 4'd0, amp: 16'd0, dc: 1'b0, last: 1'b1};

endpackage

// File: rtl/vlc_category.sv
// Clamps a signed value to +/-(2^AMP_W-1) and derives its JPEG magnitude category and amplitude bits.
module vlc_category #(
    parameter int COEF_W = 32,
    parameter int AMP_W  = 11
) (
    input  logic [COEF_W-1:0] value,
    output logic [3:0]        size,
    output logic [AMP_W-1:0]  amp
);

    localparam logic signed [COEF_W-1:0] MAX_POS = $signed({{(COEF_W-AMP_W){1'b0}}, {AMP_W{1'b1}}});
    localparam logic signed [COEF_W-1:0] MAX_NEG = -MAX_POS;

    logic signed [AMP_W:0] sat_s;
    logic [AMP_W-1:0]      mag_s;
    logic [AMP_W-1:0]      mask_s;

    // Saturate and take magnitude.
    always_comb begin
        if ($signed(value) > MAX_POS) begin
            sat_s = MAX_POS[AMP_W:0];
        end else if ($signed(value) < MAX_NEG) begin
            sat_s = MAX_NEG[AMP_W:0];
        end else begin
            sat_s = value[AMP_W:0];
        end
        if (sat_s[AMP_W]) begin
            mag_s = AMP_W'(-sat_s);
        end else begin
            mag_s = sat_s[AMP_W-1:0];
        end
    end

    // Category is the bit length of the magnitude.
    always_comb begin
        size = 4'd0;
        for (int i = 0; i < AMP_W; i++) begin
            if (mag_s[i]) begin
                size = 4'(i + 1);
            end else begin
                size = size;
            end
        end
    end

    // Negative values send the low size bits of (v-1), i.e. the ones-complement of |v|.
    always_comb begin
        for (int i = 0; i < AMP_W; i++) begin
            mask_s[i] = (i < int'(size));
        end
        if (sat_s[AMP_W]) begin
            amp = AMP_W'(sat_s - {{AMP_W{1'b0}}, 1'b1}) & mask_s;
        end else begin
            amp = sat_s[AMP_W-1:0];
        end
    end

endmodule

// File: rtl/zigzag_rle.sv
// Zigzag scan of one quantized 8x8 block into DPCM DC and run-length AC symbols for the Huffman stage.
module zigzag_rle
    import jpeg_pkg::*;
#(
    parameter int COEF_W = 32,
    parameter int AMP_W  = AMP_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          blk_valid,
    output logic                          blk_ready,
    input  logic [7:0][7:0][COEF_W-1:0]   blk,
    output logic                          sym_valid,
    input  logic                          sym_ready,
    output logic [3:0]                    sym_run,
    output logic [3:0]                    sym_size,
    output logic [AMP_W-1:0]              sym_amp,
    output logic                          sym_dc,
    output logic                          sym_last
);

    localparam logic signed [COEF_W-1:0] MAX_POS = $signed({{(COEF_W-AMP_W){1'b0}}, {AMP_W{1'b1}}});
    localparam logic signed [COEF_W-1:0] MAX_NEG = -MAX_POS;

    function automatic logic [AMP_W:0] sat_coef(input logic signed [COEF_W-1:0] v);
        if (v > MAX_POS) begin
            return MAX_POS[AMP_W:0];
        end else if (v < MAX_NEG) begin
            return MAX_NEG[AMP_W:0];
        end else begin
            return v[AMP_W:0];
        end
    endfunction

    state_t                        state_r, state_n;
    logic [5:0]                    idx_r, idx_n;
    logic [5:0]                    run_r, run_n;
    logic [AMP_W:0]                pred_r, diff_r;
    logic [7:0][7:0][COEF_W-1:0]   blk_r;

    logic                          load_s;
    logic [AMP_W:0]                dc_sat_s, diff_sat_s;
    logic [AMP_W+1:0]              diff_raw_s;
    logic [5:0]                    lin_s;
    logic [COEF_W-1:0]             coef_s, vlc_in_s;
    logic [3:0]                    vlc_size_s;
    logic [AMP_W-1:0]              vlc_amp_s;
    logic                          valid_s;
    sym_t                          sym_s;

    // DC prediction difference, computed from the incoming block so it is ready at accept.
    always_comb begin
        dc_sat_s   = sat_coef(blk[0][0]);
        diff_raw_s = {dc_sat_s[AMP_W], dc_sat_s} - {pred_r[AMP_W], pred_r};
        diff_sat_s = sat_coef({{(COEF_W-AMP_W-2){diff_raw_s[AMP_W+1]}}, diff_raw_s});
    end

    // The single category unit serves the DC difference in ST_DC and the scanned coefficient otherwise.
    always_comb begin
        lin_s  = ZZ_LUT[idx_r];
        coef_s = blk_r[lin_s[5:3]][lin_s[2:0]];
        if (state_r == ST_DC) begin
            vlc_in_s = {{(COEF_W-AMP_W-1){diff_r[AMP_W]}}, diff_r};
        end else begin
            vlc_in_s = coef_s;
        end
    end

    vlc_category #(.COEF_W(COEF_W), .AMP_W(AMP_W)) u_vlc (
        .value (vlc_in_s),
        .size  (vlc_size_s),
        .amp   (vlc_amp_s)
    );

    // Next-state and symbol presentation; nothing advances while a symbol waits for sym_ready.
    always_comb begin
        state_n = state_r;
        idx_n   = idx_r;
        run_n   = run_r;
        load_s  = 1'b0;
        valid_s = 1'b0;
        sym_s   = '0;
        case (state_r)
            ST_IDLE: begin
                if (blk_valid) begin
                    load_s  = 1'b1;
                    state_n = ST_DC;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_DC: begin
                valid_s   = 1'b1;
                sym_s.size = vlc_size_s;
                sym_s.amp  = {{(AMP_MAX_W-AMP_W){1'b0}}, vlc_amp_s};
                sym_s.dc   = 1'b1;
                if (sym_ready) begin
                    idx_n   = 6'd1;
                    run_n   = 6'd0;
                    state_n = ST_SCAN;
                end else begin
                    state_n = ST_DC;
                end
            end
            ST_SCAN: begin
                if (coef_s == '0) begin
                    if (idx_r == 6'd63) begin
                        state_n = ST_EOB;
                    end else begin
                        run_n = run_r + 6'd1;
                        idx_n = idx_r + 6'd1;
                    end
                end else if (run_r > 6'd15) begin
                    valid_s = 1'b1;
                    sym_s   = SYM_ZRL;
                    if (sym_ready) begin
                        run_n = run_r - 6'd16;
                    end else begin
                        run_n = run_r;
                    end
                end else begin
                    valid_s    = 1'b1;
                    sym_s.run  = run_r[3:0];
                    sym_s.size = vlc_size_s;
                    sym_s.amp  = {{(AMP_MAX_W-AMP_W){1'b0}}, vlc_amp_s};
                    sym_s.last = (idx_r == 6'd63);
                    if (sym_ready) begin
                        run_n = 6'd0;
                        if (idx_r == 6'd63) begin
                            state_n = ST_IDLE;
                        end else begin
                            idx_n = idx_r + 6'd1;
                        end
                    end else begin
                        run_n = run_r;
                    end
                end
            end
            ST_EOB: begin
                valid_s = 1'b1;
                sym_s   = SYM_EOB;
                if (sym_ready) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_EOB;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Control state and DC predictor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            idx_r   <= 6'd0;
            run_r   <= 6'd0;
            pred_r  <= '0;
            diff_r  <= '0;
        end else begin
            state_r <= state_n;
            idx_r   <= idx_n;
            run_r   <= run_n;
            if (load_s) begin
                pred_r <= dc_sat_s;
                diff_r <= diff_sat_s;
            end
        end
    end

    // Block holding register, written only when a new block is accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_r <= '0;
        end else if (load_s) begin
            blk_r <= blk;
        end
    end

    assign blk_ready = (state_r == ST_IDLE);
    assign sym_valid = valid_s;
    assign sym_run   = sym_s.run;
    assign sym_size  = sym_s.size;
    assign sym_amp   = sym_s.amp[AMP_W-1:0];
    assign sym_dc    = sym_s.dc;
    assign sym_last  = sym_s.last;

endmodule

// File: tb/tb_zigzag_rle.sv
// Directed bench for zigzag_rle: DC DPCM, run-length symbols, ZRL, EOB, saturation, stall and reset.
module tb_zigzag_rle;

    localparam int COEF_W = 32;
    localparam int AMP_W  = 11;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        blk_valid = 1'b0;
    logic                        blk_ready;
    logic [7:0][7:0][COEF_W-1:0] blk = '0;
    logic                        sym_valid;
    logic                        sym_ready = 1'b1;
    logic [3:0]                  sym_run, sym_size;
    logic [AMP_W-1:0]            sym_amp;
    logic                        sym_dc, sym_last;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    zigzag_rle #(.COEF_W(COEF_W), .AMP_W(AMP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk       (blk),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_run   (sym_run),
        .sym_size  (sym_size),
        .sym_amp   (sym_amp),
        .sym_dc    (sym_dc),
        .sym_last  (sym_last)
    );

    function automatic logic [20:0] mk(input logic [3:0] run, input logic [3:0] size,
                                       input logic [10:0] amp, input logic dc, input logic last);
        return {run, size, amp, dc, last};
    endfunction

    function automatic logic [20:0] cur_sym();
        return {sym_run, sym_size, sym_amp, sym_dc, sym_last};
    endfunction

    // Called at a negedge; presents the block until accepted, returns at the negedge after accept.
    task automatic send_block(output bit ok);
        ok = 1'b0;
        blk_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (!ok) begin
                if (blk_ready === 1'b1) begin
                    ok = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        blk_valid = 1'b0;
    endtask

    // Called at a negedge with sym_ready=1; returns the next symbol (X on timeout) after its handshake.
    task automatic get_sym(output logic [20:0] s);
        bit got;
        got = 1'b0;
        s = 'x;
        for (int i = 0; i < 200; i++) begin
            if (!got) begin
                if (sym_valid === 1'b1) begin
                    s = cur_sym();
                    got = 1'b1;
                    @(posedge clk);
                    @(negedge clk);
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (sym_valid !== 1'b0 || cur_sym() !== 21'd0) begin
            errors++;
            $display("FAIL reset_sym: valid=%b sym=%h expected valid=0 sym=0", sym_valid, cur_sym());
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (blk_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: blk_ready=%b expected 1", blk_ready);
        end
    endtask

    task automatic test_all_zero();
        bit ok;
        logic [20:0] s;
        blk = '0;
        send_block(ok);
        checks++;
        if (!ok || sym_valid !== 1'b1) begin
            errors++;
            $display("FAIL zero_latency: accepted=%b sym_valid=%b expected 1/1", ok, sym_valid);
        end
        get_sym(s);
        checks++;
        if (s !== mk(4'd0, 4'd0, 11'd0, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL zero_dc: got %h expected %h", s, mk(4'd0, 4'd0, 11'd0, 1'b1, 1'b0));
        end
        get_sym(s);
        checks++;
        if (s !== mk(4'd0, 4'd0, 11'd0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL zero_eob: got %h expected %h", s, mk(4'd0, 4'd0, 11'd0, 1'b0, 1'b1));
        end
        checks++;
        if (blk_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready_after: blk_ready=%b expected 1", blk_ready);
        end
    endtask

    task automatic test_dc_ac();
        bit ok;
        logic [20:0] s;
        blk = '0;
        blk[0][0] = 32'd5;
        blk[1][0] = 32'hFFFF_FFFD;
        send_block(ok);
        get_sym(s);
        checks++;
        if (s !== mk(4'd0, 4'd3, 11'd5, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL dcac_dc: got %h expected %h", s, mk(4'd0, 4'd3, 11'd5, 1'b1, 1'b0));
        end
        get_sym(s);
        checks++;
        if (s !== mk(4'd1, 4'd2, 11'd0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL dcac_ac: got %h expected %h", s, mk(4'd1, 4'd2, 11'd0, 1'b0, 1'b0));
        end
        get_sym(s);
        checks++;
        if (s !== mk(4'd0, 4'd0, 11'd0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL dcac_eob: got %h expected %h", s, mk(4'd0, 4'd0, 11'd0, 1'b0, 1'b1));
        end
    endtask

    task automatic test_dc_diff();
        bit ok;
        logic [20:0] s;
        blk = '0;
        blk[0][0] = 32'd2;
        send_block(ok);
        get_sym(s);
        checks++;
        if (s !== mk(4'd0, 4'd2, 11'd0, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL diff_dc: got %h expected %h", s, mk(4'd0, 4'd2, 11'd0, 1'b1, 1'b0));
        end
        get_sym(s);
        checks++;
        if (s !== mk(4'd0, 4'd0, 11'd0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL diff_eob: got %h expected %h", s, mk(4'd0, 4'd0, 11'd0, 1'b0, 1'b1));
        end
    endtask

    task automatic test_zrl();
        bit ok;
        logic [20:0] s;
        blk = '0;
        blk[0][0] = 32'd2;
        blk[7][7] = 32'd1;
        send_block(ok);
        get_sym(s);
        checks++;
        if (s !== mk(4'd0, 4'd0, 11'd0, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL zrl_dc: got %h expected %h", s, mk(4'd0, 4'd0, 11'd0, 1'b1, 1'b0));
        end
        for (int k = 0; k < 3; k++) begin
            get_sym(s);
            checks++;
            if (s !== mk(4'd15, 4'd0, 11'd0, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL zrl_%0d: got %h expected %h", k, s, mk(4'd15, 4'd0, 11'd0, 1'b0, 1'b0));
            end
        end
        get_sym(s);
        checks++;
        if (s !== mk(4'd14, 4'd1, 11'd1, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL zrl_last: got %h expected %h", s, mk(4'd14, 4'd1, 11'd1, 1'b0, 1'b1));
        end
        checks++;
        if (sym_valid !== 1'b0 || blk_ready !== 1'b1) begin
            errors++;
            $display("FAIL zrl_no_eob: sym_valid=%b blk_ready=%b expected 0/1", sym_valid, blk_ready);
        end
    endtask

    task automatic test_saturation_hold();
        bit ok;
        bit seen;
        logic [20:0] s;
        blk = '0;
        blk[0][1] = 32'h0000_FF00;
        blk[1][1] = 32'hFFFF_F800;
        send_block(ok);
        get_sym(s);
        checks++;
        if (s !== mk(4'd0, 4'd2, 11'd1, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL sat_dc: got %h expected %h", s, mk(4'd0, 4'd2, 11'd1, 1'b1, 1'b0));
        end
        sym_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!seen) begin
                if (sym_valid === 1'b1) seen = 1'b1;
                else @(negedge clk);
            end
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (sym_valid !== 1'b1 || cur_sym() !== mk(4'd0, 4'd11, 11'd2047, 1'b0, 1'b0)) begin
                errors++;
                $display("FAIL sat_hold_%0d: valid=%b sym=%h expected 1/%h", c, sym_valid, cur_sym(),
                         mk(4'd0, 4'd11, 11'd2047, 1'b0, 1'b0));
            end
            @(negedge clk);
        end
        sym_ready = 1'b1;
        get_sym(s);
        checks++;
        if (s !== mk(4'd0, 4'd11, 11'd2047, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL sat_pos: got %h expected %h", s, mk(4'd0, 4'd11, 11'd2047, 1'b0, 1'b0));
        end
        get_sym(s);
        checks++;
        if (s !== mk(4'd2, 4'd11, 11'd0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL sat_neg: got %h expected %h", s, mk(4'd2, 4'd11, 11'd0, 1'b0, 1'b0));
        end
        get_sym(s);
        checks++;
        if (s !== mk(4'd0, 4'd0, 11'd0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL sat_eob: got %h expected %h", s, mk(4'd0, 4'd0, 11'd0, 1'b0, 1'b1));
        end
    endtask

    task automatic test_reset_midscan();
        bit ok;
        bit seen;
        logic [20:0] s;
        blk = '0;
        blk[0][0] = 32'd7;
        blk[7][7] = 32'd1;
        send_block(ok);
        get_sym(s);
        checks++;
        if (s !== mk(4'd0, 4'd3, 11'd7, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL rst_dc7: got %h expected %h", s, mk(4'd0, 4'd3, 11'd7, 1'b1, 1'b0));
        end
        sym_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!seen) begin
                if (sym_valid === 1'b1) seen = 1'b1;
                else @(negedge clk);
            end
        end
        checks++;
        if (!seen || cur_sym() !== mk(4'd15, 4'd0, 11'd0, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL rst_zrl_wait: seen=%b sym=%h expected 1/%h", seen, cur_sym(),
                     mk(4'd15, 4'd0, 11'd0, 1'b0, 1'b0));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sym_valid !== 1'b0 || cur_sym() !== 21'd0) begin
            errors++;
            $display("FAIL rst_async: valid=%b sym=%h expected 0/0", sym_valid, cur_sym());
        end
        @(negedge clk);
        rst_n = 1'b1;
        sym_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (blk_ready !== 1'b1 || sym_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: blk_ready=%b sym_valid=%b expected 1/0", blk_ready, sym_valid);
        end
        blk = '0;
        blk[0][0] = 32'd4;
        send_block(ok);
        get_sym(s);
        checks++;
        if (s !== mk(4'd0, 4'd3, 11'd4, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL rst_pred_clear: got %h expected %h", s, mk(4'd0, 4'd3, 11'd4, 1'b1, 1'b0));
        end
        get_sym(s);
        checks++;
        if (s !== mk(4'd0, 4'd0, 11'd0, 1'b0, 1'b1)) begin
            errors++;
            $display("FAIL rst_eob: got %h expected %h", s, mk(4'd0, 4'd0, 11'd0, 1'b0, 1'b1));
        end
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_dc_ac();
        test_dc_diff();
        test_zrl();
        test_saturation_hold();
        test_reset_midscan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/zigzag_rle.md
Name: zigzag_rle

Overview:
- Downstream neighbour of dct_cl_quant. Consumes one quantized 8x8 coefficient block at a time.
- Walks the block in JPEG zigzag order and DPCM-codes the DC term against the previous block.
- Run-length encodes the 63 AC terms into (run, size, amplitude) symbols, including ZRL and EOB.
- Symbols stream out on a valid/ready interface to the Huffman/bitpacker stage.

Parameters:
COEF_W, 32, width of each input coefficient (signed two's complement)
AMP_W, 11, amplitude field width; also the saturation limit (max magnitude 2^AMP_W-1)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  reset, asynchronous and active-low
blk_valid  input  1  blk holds a complete quantized block
blk_ready  output  1  block accepted when blk_valid && blk_ready
blk  input  [7:0][7:0][COEF_W-1:0]  coefficients, indexed blk[row][col], linear index row*8+col
sym_valid  output  1  symbol fields valid
sym_ready  input  1  downstream accepts symbol
sym_run  output  4  preceding zero run (0-15)
sym_size  output  4  magnitude category (0-AMP_W)
sym_amp  output  AMP_W  amplitude bits, zero-extended above sym_size
sym_dc  output  1  symbol is the DC difference
sym_last  output  1  final symbol of block

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; DC predictor=0; scan index=0; run=0.
  - All sym_* outputs=0; blk_ready=1 once released.
  - Any partially emitted block is discarded.
- FSM states: IDLE, DC, SCAN, EOB.
- IDLE:
  - blk_ready=1.
  - On accept: register all 64 coefficients.
  - diff = sat(blk[0][0]) - pred, then saturate diff; pred <= sat(blk[0][0]).
  - Next state DC.
  - The DC symbol has sym_valid=1 on the cycle after accept (latency 1).
- blk_ready=0 in every state except IDLE. The block register is never overwritten mid-block.
- DC state:
  - Present {run=0, size(diff), amp(diff), sym_dc=1, sym_last=0}.
  - On handshake: idx=1, run=0, go SCAN.
- SCAN state: examines coefficient c = blk[zz[idx]], one per cycle.
  - c==0, idx<63: run++, idx++. No symbol; sym_valid=0.
  - c==0, idx==63: go EOB.
  - c!=0, run>15: present ZRL {15,0,0}. On handshake run-=16; idx unchanged.
  - c!=0, run<=15: present {run, size(c), amp(c)}, sym_last=(idx==63). On handshake run=0, idx++. If idx was 63, go IDLE.
- EOB state: present {0,0,0, sym_last=1}; on handshake go IDLE.
- Handshake hold: while sym_valid && !sym_ready, all sym_* fields are held stable and no state advances.
- sym_valid never drops without a handshake.
- Next block: accepted no earlier than the cycle after the last handshake (IDLE cycle). Throughput is at most 65 symbol cycles plus zero-scan cycles per block.
- Saturation: every coefficient and the DC diff are clamped to ±(2^AMP_W-1) before size/amp are computed.
- size(v) = bit length of |v|, with size(0)=0.
- amp(v):
  - v>0: v.
  - v<0: low size bits of (v-1).
  - Bits above size are 0.
- Zigzag order is the standard JPEG order: zz = 0,1,8,16,9,2,3,10,17,24, ... ,62,63.

Decomposition:
- jpeg_pkg:
  - ZZ_LUT: 64-entry constant of linear indices.
  - sym_t: struct {run, size, amp, dc, last}.
  - fsm state enum.
  - ZRL/EOB constants.
  - AMP_W default.
- Sub-module vlc_category (combinational): saturate → size/amp. Single instance, muxed between DC diff and current AC coefficient.

Test Plan:
1. All-zero block, pred=0 -> DC {0,0,0,dc=1}, then EOB {0,0,0,last=1}; blk_ready high next cycle.
2. blk[0][0]=5, blk[1][0]=-3 (idx 2), rest 0 -> DC {0,3,5}; {run=1,size=2,amp=2'b00}; EOB last.
3. After test 2, next block blk[0][0]=2, rest 0 -> DC diff -3 -> {0,2,2'b00}, then EOB.
4. Only blk[7][7]=1 -> DC {0,0,0}; ZRL {15,0,0} ×3; {run=14,size=1,amp=1,last=1}; no EOB.
5. Saturation: blk[0][1]=32'h0000ff00, blk[0][0]=0 -> AC {0,11,2047}. Then hold sym_ready=0 for 3 cycles mid-stream -> fields stable, no symbol lost or duplicated.
6. Drop rst_n during the SCAN of test 4 -> sym_valid=0 immediately. After release blk_ready=1; a new block with blk[0][0]=4 gives DC amp 4 (pred cleared).
